// File: rtl/bcd_updown_counter_pkg.sv
// ============================================================================
// Module : bcd_cnt_pkg
// Desc   : Shared mode encodings, digit type and helpers for the BCD counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_cnt_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_updown_counter_if.sv
// ============================================================================
// Module : bcd_updown_counter_if
// Desc   : Control/status bundle of the BCD counter. Optional sat_en is only
//          present when BCD_CNT_SAT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
`ifdef BCD_CNT_SAT_EN
    logic                  sat_en;
`endif
    logic                  en;
    logic [1:0]            mode;
    logic                  load_en;
    logic [4*DIGITS-1:0]   load;
    logic [4*DIGITS-1:0]   count;
    logic                  cout;
    logic                  bout;
    logic                  tc;
    logic                  load_err;

    modport master (
`ifdef BCD_CNT_SAT_EN
        output sat_en,
`endif
        output en, mode, load_en, load,
        input  count, cout, bout, tc, load_err
    );

    modport slave (
`ifdef BCD_CNT_SAT_EN
        input  sat_en,
`endif
        input  en, mode, load_en, load,
        output count, cout, bout, tc, load_err
    );

endinterface

`default_nettype wire

// File: rtl/bcd_updown_counter_slice.sv
// ============================================================================
// Module : bcd_digit_slice
// Desc   : One BCD digit register with load, wrapping increment and decrement.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_slice
    import bcd_cnt_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       a_clr,
    input  wire logic       inc,
    input  wire logic       dec,
    input  wire logic       ld,
    input  wire bcd_digit_t ld_digit,
    output bcd_digit_t      digit,
    output logic            is9,
    output logic            is0
);

    bcd_digit_t r_digit;

    always_ff @(posedge clk or negedge a_clr) begin
        if (!a_clr) begin
            r_digit <= '0;
        end else if (ld) begin
            r_digit <= ld_digit;
        end else if (inc) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end else if (dec) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign digit = r_digit;
    assign is9   = (r_digit == BCD_MAX);
    assign is0   = (r_digit == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module : bcd_updown_counter
// Desc   : DIGITS-digit BCD up/down counter with sanitised load and wrap flags.
//          Define BCD_CNT_SAT_EN to add sat_en (saturate instead of wrap).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic            clk,
    input  wire logic            a_clr,
    bcd_updown_counter_if.slave  bus
);

    logic [DIGITS-1:0] w_is9;
    logic [DIGITS-1:0] w_is0;
    logic [DIGITS-1:0] w_lo9;   // all digits below i are 9
    logic [DIGITS-1:0] w_lo0;   // all digits below i are 0
    logic [DIGITS-1:0] w_bad;
    logic              w_all9;
    logic              w_all0;
    logic              w_sat;
    logic              w_up_go;
    logic              w_dn_go;
    logic              r_cout;
    logic              r_bout;
    logic              r_load_err;

`ifdef BCD_CNT_SAT_EN
    assign w_sat = bus.sat_en;
`else
    assign w_sat = 1'b0;
`endif

    assign w_all9  = w_lo9[DIGITS-1] & w_is9[DIGITS-1];
    assign w_all0  = w_lo0[DIGITS-1] & w_is0[DIGITS-1];
    assign w_up_go = bus.en && (bus.mode == MODE_UP) && !(w_sat && w_all9);
    assign w_dn_go = bus.en && (bus.mode == MODE_DN) && !(w_sat && w_all0);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_t w_ld_raw;
        bcd_digit_t w_ld_digit;

        assign w_ld_raw   = bus.load[4*i +: 4];
        assign w_bad[i]   = !bcd_valid(w_ld_raw);
        assign w_ld_digit = w_bad[i] ? 4'd0 : w_ld_raw;

        if (i == 0) begin : g_lsd
            assign w_lo9[i] = 1'b1;
            assign w_lo0[i] = 1'b1;
        end else begin : g_upper
            assign w_lo9[i] = w_lo9[i-1] & w_is9[i-1];
            assign w_lo0[i] = w_lo0[i-1] & w_is0[i-1];
        end

        bcd_digit_slice u_slice (
            .clk      (clk),
            .a_clr    (a_clr),
            .inc      (w_up_go & w_lo9[i]),
            .dec      (w_dn_go & w_lo0[i]),
            .ld       (bus.load_en),
            .ld_digit (w_ld_digit),
            .digit    (bus.count[4*i +: 4]),
            .is9      (w_is9[i]),
            .is0      (w_is0[i])
        );
    end

    // A load edge never reports a wrap; only rejected digits raise load_err
    always_ff @(posedge clk or negedge a_clr) begin
        if (!a_clr) begin
            r_cout     <= 1'b0;
            r_bout     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.load_en) begin
            r_cout     <= 1'b0;
            r_bout     <= 1'b0;
            r_load_err <= |w_bad;
        end else begin
            r_cout     <= w_up_go & w_all9;
            r_bout     <= w_dn_go & w_all0;
            r_load_err <= 1'b0;
        end
    end

    assign bus.cout     = r_cout;
    assign bus.bout     = r_bout;
    assign bus.load_err = r_load_err;
    assign bus.tc       = ((bus.mode == MODE_UP) && w_all9) ||
                          ((bus.mode == MODE_DN) && w_all0);

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
// Module : tb_bcd_updown_counter
// Desc   : Directed-vector scoreboard bench for the 4-digit BCD counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_updown_counter;

    typedef struct {
        int          id;
        logic [15:0] cnt;
        logic        co;
        logic        bo;
        logic        le;
        logic        tc;
    } exp_t;

    logic clk   = 1'b0;
    logic a_clr = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(4)) bus ();

    bcd_updown_counter #(.DIGITS(4)) dut (
        .clk   (clk),
        .a_clr (a_clr),
        .bus   (bus)
    );

    task automatic check_now(input string name, input logic [15:0] xc,
                             input logic xco, input logic xbo, input logic xle);
        checks++;
        if (bus.count !== xc || bus.cout !== xco || bus.bout !== xbo || bus.load_err !== xle) begin
            failures++;
            $display("FAIL %s: got count=%h cout=%b bout=%b lerr=%b, want count=%h cout=%b bout=%b lerr=%b",
                     name, bus.count, bus.cout, bus.bout, bus.load_err, xc, xco, xbo, xle);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge
    task automatic step(input logic e, input logic [1:0] m, input logic le, input logic [15:0] lv,
                        input logic [15:0] xc, input logic xco, input logic xbo,
                        input logic xle, input logic xtc);
        exp_t x;
        @(negedge clk);
        bus.en      = e;
        bus.mode    = m;
        bus.load_en = le;
        bus.load    = lv;
        x.id  = vec_id++;
        x.cnt = xc; x.co = xco; x.bo = xbo; x.le = xle; x.tc = xtc;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (bus.count !== x.cnt || bus.cout !== x.co || bus.bout !== x.bo ||
                    bus.load_err !== x.le || bus.tc !== x.tc) begin
                    failures++;
                    $display("FAIL vec%0d: got count=%h cout=%b bout=%b lerr=%b tc=%b, want count=%h cout=%b bout=%b lerr=%b tc=%b",
                             x.id, bus.count, bus.cout, bus.bout, bus.load_err, bus.tc,
                             x.cnt, x.co, x.bo, x.le, x.tc);
                end
            end
        end
    end

    initial begin : stim
        int budget;
        bus.en = 1'b0; bus.mode = 2'b00; bus.load_en = 1'b0; bus.load = '0;
`ifdef BCD_CNT_SAT_EN
        bus.sat_en = 1'b0;
`endif
        #2;
        check_now("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a_clr = 1'b1;

        // Asynchronous clear while counting
        step(1, 2'b01, 1, 16'h1233, 16'h1233, 0, 0, 0, 0);
        step(1, 2'b01, 0, 16'h0000, 16'h1234, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        a_clr = 1'b0;
        #1;
        check_now("async_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        bus.en = 1'b0; bus.load_en = 1'b0;
        @(negedge clk);
        a_clr = 1'b1;
        step(1, 2'b01, 0, 16'h0000, 16'h0001, 0, 0, 0, 0);

        // Up counting with carry propagation and full wrap
        step(1, 2'b01, 1, 16'h0998, 16'h0998, 0, 0, 0, 0);
        step(1, 2'b01, 0, 16'h0000, 16'h0999, 0, 0, 0, 0);
        step(1, 2'b01, 0, 16'h0000, 16'h1000, 0, 0, 0, 0);
        step(1, 2'b01, 1, 16'h9999, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
        step(1, 2'b01, 0, 16'h0000, 16'h0001, 0, 0, 0, 0);

        // Down counting with borrow propagation and full wrap
        step(1, 2'b10, 1, 16'h0000, 16'h0000, 0, 0, 0, 1);
        step(1, 2'b10, 0, 16'h0000, 16'h9999, 0, 1, 0, 0);
        step(1, 2'b10, 0, 16'h0000, 16'h9998, 0, 0, 0, 0);
        step(1, 2'b10, 1, 16'h1000, 16'h1000, 0, 0, 0, 0);
        step(1, 2'b10, 0, 16'h0000, 16'h0999, 0, 0, 0, 0);

        // Sanitised load, load priority over counting
        step(1, 2'b01, 1, 16'h3A5F, 16'h3050, 0, 0, 1, 0);
        step(1, 2'b00, 0, 16'h0000, 16'h3050, 0, 0, 0, 0);
        step(1, 2'b01, 1, 16'h4321, 16'h4321, 0, 0, 0, 0);

        // Hold by en=0 and by mode=11
        step(0, 2'b01, 0, 16'h0000, 16'h4321, 0, 0, 0, 0);
        step(0, 2'b10, 0, 16'h0000, 16'h4321, 0, 0, 0, 0);
        step(0, 2'b01, 0, 16'h0000, 16'h4321, 0, 0, 0, 0);
        step(1, 2'b11, 0, 16'h0000, 16'h4321, 0, 0, 0, 0);
        step(1, 2'b11, 0, 16'h0000, 16'h4321, 0, 0, 0, 0);

        // Load at all-9s suppresses the wrap; en=0 at all-9s still shows tc
        step(1, 2'b01, 1, 16'h9999, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 1, 16'h9999, 16'h9999, 0, 0, 0, 1);
        step(0, 2'b01, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
        step(0, 2'b10, 0, 16'h0000, 16'h0000, 0, 0, 0, 1);

`ifdef BCD_CNT_SAT_EN
        @(negedge clk);
        bus.sat_en = 1'b1;
        step(1, 2'b01, 1, 16'h9999, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b01, 0, 16'h0000, 16'h9999, 0, 0, 0, 1);
        step(1, 2'b10, 1, 16'h0000, 16'h0000, 0, 0, 0, 1);
        step(1, 2'b10, 0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        step(1, 2'b10, 0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        @(negedge clk);
        bus.sat_en = 1'b0;
        q.push_back('{id: vec_id++, cnt: 16'h9999, co: 1'b0, bo: 1'b1, le: 1'b0, tc: 1'b0});
`endif

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
